branch_predict_param: RTL
=========================

# branch_predict_param

Parametrised dynamic branch direction predictor for the 5-stage MIPS pipeline. It predicts in Fetch and carries the prediction to Decode. It updates its tables when a branch reaches Memory. Build-time parameters select local-history (per-PC BHT) or gshare (global history) mode and set the table sizes and counter width. Tables are initialised by a sweep FSM after reset, and two saturating performance counters track branches and mispredictions.

## Interface
- `BHT_BITS`, 10: BHT index width; BHT entries = 2^BHT_BITS, indexed by `pc[BHT_BITS+1:2]` (local mode only).
- `HIST_LEN`, 6: history register width, 1..PHT_BITS.
- `PHT_BITS`, 6: PHT index width; PHT entries = 2^PHT_BITS.
- `CTR_BITS`, 2: saturating counter width, 1..4.
- `MODE`, 0: 0 = local history from BHT; 1 = gshare, using a single global history register (GHR).
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flushD` in 1: clear the F→D prediction register.
- `stallD` in 1: hold the F→D prediction register.
- `pcF` in 32: Fetch PC.
- `pcM` in 32: Memory-stage PC.
- `branchD` in 1: Decode instruction is a conditional branch.
- `branchM` in 1: Memory instruction is a conditional branch.
- `actual_takeM` in 1: resolved direction of the Memory branch.
- `pred_wrongM` in 1: the Memory branch was mispredicted.
- `pred_takeF` out 1: Fetch prediction.
- `pred_takeD` out 1: Decode prediction.
- `ready` out 1: tables initialised.
- `branch_cnt` out 32: count of updated branches.
- `miss_cnt` out 32: count of mispredicted updated branches.

## Operation
- History source H:
  - Local mode: `BHT[pc[BHT_BITS+1:2]]`.
  - Gshare mode: GHR.
- PHT index = zero-extended H XOR `pc[PHT_BITS+1:2]`. Fetch uses `pcF`; update uses `pcM`.
- `pred_takeF` = MSB of `PHT[indexF]` when `ready` = 1, else 0.
- Counter encoding is plain binary: 0 = strongly not-taken, 2^CTR_BITS−1 = strongly taken. Initial value is weakly taken, 2^(CTR_BITS−1).
- Update condition: `branchM & ready`. When it holds:
  - PHT counter: +1 if `actual_takeM`, else −1, saturating at both ends.
  - Local mode: `BHT[idxM] <= {BHT[idxM][HIST_LEN-2:0], actual_takeM}`.
  - Gshare mode: GHR shifts in the same way.
  - Update index is computed from the history value *before* this shift.
- History is non-speculative: it changes only on a Memory update.
- FSM states:
  - INIT: entered on `rst`. A sweep counter runs 0..N−1, with N = max(2^BHT_BITS, 2^PHT_BITS). Each cycle it writes BHT[i] = 0 (if i < 2^BHT_BITS) and PHT[i] = weakly taken (if i < 2^PHT_BITS). GHR = 0. `ready` = 0, and all updates and count increments are ignored. After writing i = N−1, go to RUN.
  - RUN: `ready` = 1. Stays in RUN until `rst`.
- `rst` asserted in any state, including mid-INIT, restarts the sweep at 0.
- F→D register:
  - `rst` or `flushD` clears it to 0.
  - Otherwise, `~stallD` loads `pred_takeF`.
  - Otherwise it holds.
  - flushD has priority over stallD.
- `pred_takeD` = `branchD & register`.
- Perf counters:
  - Reset to 0 when `rst` is asserted.
  - `branch_cnt` +1 on each update.
  - `miss_cnt` +1 on each update with `pred_wrongM` = 1.
  - Both saturate at 0xFFFFFFFF.
- Tables are synchronous-write with asynchronous read. A Fetch read and a Memory write to the same entry in the same cycle return the old value. No bypass.

## Timing
- Output values while `rst` is held and through the whole INIT sweep: `pred_takeF` = 0, `pred_takeD` = 0, `ready` = 0, counters = 0.
- `ready` rises exactly N cycles after the cycle in which `rst` is deasserted. With defaults, N = 1024.
- `pred_takeF` is combinational from `pcF`, with zero latency.
- `pred_takeD` is valid one cycle after the corresponding `pcF`.
- An update becomes visible to a Fetch read in the cycle after `branchM`.
- Counters reflect an update in the following cycle.

## Test plan
- **Reset sweep.** Defaults; deassert `rst`.
  - `ready` = 0 for 1024 cycles, then 1.
  - Any `pcF` then gives `pred_takeF` = 1 (counter = 2'b10).
  - `branchM` pulses during INIT leave `branch_cnt` = 0.
- **Saturation.** Local mode, `pcM` = `pcF` = 0x00400010.
  - Constant history path (history held at all-ones after ≥ HIST_LEN taken updates): 3 not-taken updates drive the counter to 0, then `pred_takeF` = 0; a 4th not-taken update keeps it at 0.
  - 2 taken updates from 0 give 2, and `pred_takeF` = 1.
- **History shift.** Local mode, alternating T/N on one PC.
  - The BHT entry follows 000001, 000010, 000101, and so on.
  - Different PHT entries are trained, and the prediction alternates after warm-up.
- **Gshare aliasing.** MODE = 1. Update at PC A changes the GHR, so the PHT index for PC B differs from before. Check against a reference model.
- **Pipeline control.**
  - `pred_takeF` = 1 with `stallD` = 1: `pred_takeD` keeps its old value.
  - `flushD` and `stallD` both 1: the register is 0.
  - `branchD` = 0 forces `pred_takeD` = 0.
- **Same-cycle collision, reset mid-INIT, and counter saturation.**
  - Fetch reads the entry being updated and sees the old value.
  - `rst` at sweep index 500 restarts the sweep, giving 1024 more cycles to `ready`.
  - Preload `miss_cnt` to 0xFFFFFFFF by force; the next miss holds it at 0xFFFFFFFF.

Source files
------------

// File: rtl/branch_predict_param.sv
// branch_predict_param: local/gshare dynamic branch direction predictor with table init sweep and perf counters.
module branch_predict_param #(
  parameter int BHT_BITS = 10,
  parameter int HIST_LEN = 6,
  parameter int PHT_BITS = 6,
  parameter int CTR_BITS = 2,
  parameter int MODE     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flushD,
  input  logic        stallD,
  input  logic [31:0] pcF,
  input  logic [31:0] pcM,
  input  logic        branchD,
  input  logic        branchM,
  input  logic        actual_takeM,
  input  logic        pred_wrongM,
  output logic        pred_takeF,
  output logic        pred_takeD,
  output logic        ready,
  output logic [31:0] branch_cnt,
  output logic [31:0] miss_cnt
);
  localparam int SW = BHT_BITS > PHT_BITS ? BHT_BITS : PHT_BITS;
  localparam logic [SW-1:0] LAST = '1;
  localparam logic [CTR_BITS-1:0] WEAK = CTR_BITS'(2 ** (CTR_BITS - 1));
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [SW-1:0] sweep;
  logic [HIST_LEN-1:0] histF, histM, histNext;
  logic [PHT_BITS-1:0] idxF, idxM;
  logic [CTR_BITS-1:0] pht [2 ** PHT_BITS];
  logic [CTR_BITS-1:0] ctrM, ctrNext;
  logic upd, predReg, unused_pc;
  assign unused_pc = ^{pcF, pcM};
  assign ready = state == RUN;
  assign upd = branchM & ready & ~rst;
  // Update index uses the history before this branch is shifted in.
  assign histNext = HIST_LEN'({histM, actual_takeM});
  assign idxF = PHT_BITS'(histF) ^ pcF[PHT_BITS+1:2];
  assign idxM = PHT_BITS'(histM) ^ pcM[PHT_BITS+1:2];
  assign ctrM = pht[idxM];
  assign ctrNext = actual_takeM ? (&ctrM ? ctrM : ctrM + CTR_BITS'(1))
                                : (|ctrM ? ctrM - CTR_BITS'(1) : ctrM);
  assign pred_takeF = ready & pht[idxF][CTR_BITS-1];
  assign pred_takeD = branchD & predReg;
  always_ff @(posedge clk)
    if (rst) begin
      state <= INIT;
      sweep <= '0;
    end else if (state == INIT) begin
      sweep <= sweep + SW'(1);
      if (sweep == LAST) state <= RUN;
    end
  always_ff @(posedge clk)
    if (state == INIT) begin
      if (int'(sweep) < 2 ** PHT_BITS) pht[sweep[PHT_BITS-1:0]] <= WEAK;
    end else if (upd) pht[idxM] <= ctrNext;
  generate
    if (MODE == 0) begin : g_local
      logic [HIST_LEN-1:0] bht [2 ** BHT_BITS];
      assign histF = bht[pcF[BHT_BITS+1:2]];
      assign histM = bht[pcM[BHT_BITS+1:2]];
      always_ff @(posedge clk)
        if (state == INIT) begin
          if (int'(sweep) < 2 ** BHT_BITS) bht[sweep[BHT_BITS-1:0]] <= '0;
        end else if (upd) bht[pcM[BHT_BITS+1:2]] <= histNext;
    end else begin : g_gshare
      logic [HIST_LEN-1:0] ghr;
      assign histF = ghr;
      assign histM = ghr;
      always_ff @(posedge clk)
        if (rst || state == INIT) ghr <= '0;
        else if (upd) ghr <= histNext;
    end
  endgenerate
  always_ff @(posedge clk)
    if (rst || flushD) predReg <= 1'b0;
    else if (!stallD) predReg <= pred_takeF;
  always_ff @(posedge clk)
    if (rst) begin
      branch_cnt <= '0;
      miss_cnt <= '0;
    end else if (upd) begin
      if (~&branch_cnt) branch_cnt <= branch_cnt + 32'd1;
      if (pred_wrongM && ~&miss_cnt) miss_cnt <= miss_cnt + 32'd1;
    end
endmodule
